// File: rtl/lc3b_mem_sequencer.sv
// LC-3b MEM-stage sequencer: turns LDR/LDB/STR/STB/LDI/STI into one or two handshaked
// data-memory accesses, aligns byte data, and stalls the pipeline until the sequence completes.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef enum logic [3:0] {
    op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
    op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
    op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
    op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;
endpackage

module lc3b_mem_sequencer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  lc3b_opcode    in_opcode,
  input  lc3b_word      in_addr,
  input  lc3b_word      in_sr,
  input  logic          advance,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      load_data,
  output logic          mem_done,
  output logic          stall
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_HOLD} state_e;

  state_e        state_q, state_d;
  lc3b_opcode    op_q, op_d;
  logic          byte_hi_q, byte_hi_d;
  lc3b_word      sr_q, sr_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  lc3b_word      mem_address_q, mem_address_d;
  lc3b_word      mem_wdata_q, mem_wdata_d;
  lc3b_mem_wmask mem_byte_enable_q, mem_byte_enable_d;
  lc3b_word      load_data_q, load_data_d;
  logic          mem_done_q, mem_done_d;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
  endfunction

  function automatic lc3b_word sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  always_comb begin
    // NOTE: every *_d starts from its flop value, so no path through this block can infer a latch.
    state_d           = state_q;
    op_d              = op_q;
    byte_hi_d         = byte_hi_q;
    sr_d              = sr_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_wdata_d       = mem_wdata_q;
    mem_byte_enable_d = mem_byte_enable_q;
    load_data_d       = load_data_q;
    mem_done_d        = mem_done_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && is_mem_op(in_opcode)) begin
          state_d           = S_FIRST;
          op_d              = in_opcode;
          byte_hi_d         = in_addr[0];
          sr_d              = in_sr;
          mem_address_d     = {in_addr[15:1], 1'b0};
          mem_byte_enable_d = 2'b11;
          if (in_opcode == op_str || in_opcode == op_stb) begin
            mem_write_d = 1'b1;
            mem_wdata_d = in_sr;
            if (in_opcode == op_stb) begin
              mem_wdata_d       = {in_sr[7:0], in_sr[7:0]};
              mem_byte_enable_d = in_addr[0] ? 2'b10 : 2'b01;
            end
          end else begin
            mem_read_d = 1'b1;
          end
        end
      end

      S_FIRST: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          case (op_q)
            op_ldi, op_sti: begin
              // The first read returned a pointer; the follow-up access is forced word-aligned.
              state_d           = S_SECOND;
              mem_address_d     = {mem_rdata[15:1], 1'b0};
              mem_byte_enable_d = 2'b11;
              if (op_q == op_sti) begin
                mem_write_d = 1'b1;
                mem_wdata_d = sr_q;
              end else begin
                mem_read_d = 1'b1;
              end
            end
            op_ldr: begin
              load_data_d = mem_rdata;
              state_d     = S_HOLD;
              mem_done_d  = 1'b1;
            end
            op_ldb: begin
              load_data_d = sext_byte(byte_hi_q ? mem_rdata[15:8] : mem_rdata[7:0]);
              state_d     = S_HOLD;
              mem_done_d  = 1'b1;
            end
            default: begin
              state_d    = S_HOLD;
              mem_done_d = 1'b1;
            end
          endcase
        end
      end

      S_SECOND: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (op_q == op_ldi) load_data_d = mem_rdata;
          state_d    = S_HOLD;
          mem_done_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (advance) begin
          state_d    = S_IDLE;
          mem_done_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: latched operands are cleared as well, so nothing from an aborted sequence survives.
      state_q           <= S_IDLE;
      op_q              <= op_br;
      byte_hi_q         <= 1'b0;
      sr_q              <= '0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
      mem_byte_enable_q <= '0;
      load_data_q       <= '0;
      mem_done_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_d;
      byte_hi_q         <= byte_hi_d;
      sr_q              <= sr_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_wdata_q       <= mem_wdata_d;
      mem_byte_enable_q <= mem_byte_enable_d;
      load_data_q       <= load_data_d;
      mem_done_q        <= mem_done_d;
    end
  end

  assign stall = (state_q == S_IDLE && in_valid && is_mem_op(in_opcode))
               || state_q == S_FIRST || state_q == S_SECOND;

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_byte_enable_q;
  assign load_data       = load_data_q;
  assign mem_done        = mem_done_q;

endmodule
